parc_dmemresp_queue: RTL and testbench
======================================

PARC_DMEMRESP_QUEUE -- requirements
Module: parc_dmemresp_queue

Interface
REQ-001 Parameter p_depth, default 2: entry count; legal range 1..16.
REQ-002 Parameter p_bypass, default 1: 1 enables empty-queue combinational pass-through; 0 disables it.
REQ-003 Parameter p_cnt_nbits, default 5: count width; must satisfy 2^p_cnt_nbits > p_depth.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enq_val  input  1  dmem response valid.
REQ-007 enq_rdy  output  1  queue accepts a response this cycle.
REQ-008 enq_data  input  32  raw dmem response word.
REQ-009 enq_type  input  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5..7 illegal.
REQ-010 enq_offset  input  2  byte address bits [1:0] of the load.
REQ-011 deq_val  output  1  formatted result valid.
REQ-012 deq_rdy  input  1  consumer (writeback mux) accepts the result.
REQ-013 deq_data  output  32  formatted load result.
REQ-014 count  output  p_cnt_nbits  number of stored entries.
REQ-015 full, empty  output  1 each  count==p_depth, count==0.
REQ-016 err_type  output  1  sticky flag: an illegal enq_type was enqueued.

Function
REQ-017 Format every response before storage: lw passes the word; lb/lbu select byte enq_offset, sign-/zero-extended; lh/lhu select halfword enq_offset[1], sign-/zero-extended; enq_offset[0] is ignored for halfwords.
REQ-018 Illegal types store 32'h0 and set err_type, which stays set until reset.
REQ-019 enq_rdy = !full && !reset; an enqueue occurs when enq_val && enq_rdy.
REQ-020 deq_val = !empty || (p_bypass && enq_val); a dequeue occurs when deq_val && deq_rdy.
REQ-021 When non-empty, deq_data is the head entry (FIFO order).
REQ-022 When empty, p_bypass=1 and enq_val=1, deq_data is the formatted enq_data in the same cycle (zero latency).
REQ-023 An empty-bypass transfer with deq_rdy=1 leaves count, pointers and storage unchanged.
REQ-024 An empty-bypass offer with deq_rdy=0 writes the entry normally; count becomes 1.
REQ-025 With p_bypass=0 or non-empty, latency from enqueue to deq_val is one cycle minimum.
REQ-026 Simultaneous enqueue and dequeue when non-empty: both pointers advance and count is unchanged.
REQ-027 Simultaneous enqueue and dequeue when full: not possible, because enq_rdy=0.
REQ-028 Pointers wrap from p_depth-1 to 0, including for non-power-of-two depths.
REQ-029 Dequeue with no enqueue decrements count; enqueue with no dequeue increments count.
REQ-030 deq_data is don't-care when deq_val=0; the bench shall not check it.

Reset
REQ-031 Asynchronous assertion immediately clears count, pointers and err_type, drives deq_val=0 and enq_rdy=0, sets empty=1 and full=0, and discards in-flight entries.
REQ-032 Storage contents are not reset.
REQ-033 After deassertion: enq_rdy=1 on the first clock edge; no enqueue is accepted while reset is high.

Structure
REQ-034 Shared package parc_dmemresp_pkg holds the load-type constants (LD_W..LD_HU) and the 3-bit type typedef; the control unit uses the same package.
REQ-035 One combinational sub-module, parc_dmemresp_subword (data, type, offset -> formatted data, illegal flag), instantiated once on the enqueue path.
REQ-036 Storage is a p_depth x 32 register array; head pointer, tail pointer and counter are the only control state.

Verification
REQ-037 Reset, then enq lb with data 32'h1234_80FF, offset 1, p_bypass=1, deq_rdy=1 -> same-cycle deq_data=32'hFFFF_FF80; count stays 0.
REQ-038 Hold deq_rdy=0 and enq lhu 32'hBEEF_0001, offset 2, then lw 32'hCAFE_F00D (depth 2) -> full=1, enq_rdy=0; raise deq_rdy -> deq 32'h0000_BEEF, then 32'hCAFE_F00D.
REQ-039 Depth 3: stream 10 words, enq and deq both active every cycle -> in-order output, count constant, pointers wrap correctly.
REQ-040 enq_type=6 with data 32'hFFFF_FFFF -> deq_data=0, err_type=1 until the next reset.
REQ-041 Assert reset mid-stream with count=2 -> count=0, deq_val=0 and empty=1 before the next clock edge; previous data never appears.
REQ-042 p_bypass=0, enq on an empty queue -> deq_val=0 that cycle and 1 the next cycle, with correct data.

Source files
------------

// File: rtl/parc_dmemresp_pkg.sv
// parc_dmemresp_pkg: load-type encoding shared by the dmem response path
package parc_dmemresp_pkg;
  typedef logic [2:0] ld_type_t;
  localparam ld_type_t LD_W  = 3'd0;
  localparam ld_type_t LD_B  = 3'd1;
  localparam ld_type_t LD_BU = 3'd2;
  localparam ld_type_t LD_H  = 3'd3;
  localparam ld_type_t LD_HU = 3'd4;
  function automatic logic ld_illegal(input ld_type_t t);
    return t > LD_HU;
  endfunction
endpackage

// File: rtl/parc_dmemresp_subword.sv
// parc_dmemresp_subword: extracts and extends the addressed byte/halfword of a load response
module parc_dmemresp_subword
  import parc_dmemresp_pkg::*;
(
  input  logic [31:0] data,
  input  ld_type_t    typ,
  input  logic [1:0]  offset,
  output logic [31:0] fmt,
  output logic        illegal
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = data[{offset, 3'b000} +: 8];
    h = offset[1] ? data[31:16] : data[15:0];
    illegal = ld_illegal(typ);
    fmt = typ == LD_W  ? data :
          typ == LD_B  ? {{24{b[7]}}, b} :
          typ == LD_BU ? {24'h0, b} :
          typ == LD_H  ? {{16{h[15]}}, h} :
          typ == LD_HU ? {16'h0, h} : 32'h0;
  end
endmodule

// File: rtl/parc_dmemresp_queue.sv
// parc_dmemresp_queue: formats dmem load responses and buffers them for writeback,
// with optional zero-latency pass-through when empty
module parc_dmemresp_queue
  import parc_dmemresp_pkg::*;
#(
  parameter int p_depth     = 2,
  parameter bit p_bypass    = 1,
  parameter int p_cnt_nbits = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [31:0]            enq_data,
  input  logic [2:0]             enq_type,
  input  logic [1:0]             enq_offset,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [31:0]            deq_data,
  output logic [p_cnt_nbits-1:0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   err_type
);
  localparam int PW = p_depth > 1 ? $clog2(p_depth) : 1;
  localparam logic [PW-1:0] LAST = PW'(p_depth - 1);
  localparam logic [p_cnt_nbits-1:0] DEPTH = p_cnt_nbits'(p_depth);
  logic [31:0] mem_q [p_depth];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [p_cnt_nbits-1:0] count_q, count_d;
  logic err_q, err_d;
  logic [31:0] fmt;
  logic illegal, bypass, enq_fire, do_enq, do_deq;
  parc_dmemresp_subword u_subword (
    .data    (enq_data),
    .typ     (enq_type),
    .offset  (enq_offset),
    .fmt     (fmt),
    .illegal (illegal)
  );
  always_comb begin
    full = count_q == DEPTH;
    empty = count_q == '0;
    count = count_q;
    err_type = err_q;
    enq_rdy = !full && !reset;
    bypass = p_bypass && empty && enq_val && !reset;
    deq_val = !reset && (!empty || bypass);
    deq_data = empty ? fmt : mem_q[head_q];
    enq_fire = enq_val && enq_rdy;
    // a bypass that is consumed this cycle never touches storage
    do_enq = enq_fire && !(bypass && deq_rdy);
    do_deq = deq_val && deq_rdy && !empty;
    head_d = do_deq ? (head_q == LAST ? '0 : head_q + 1'b1) : head_q;
    tail_d = do_enq ? (tail_q == LAST ? '0 : tail_q + 1'b1) : tail_q;
    count_d = count_q + p_cnt_nbits'(do_enq) - p_cnt_nbits'(do_deq);
    err_d = err_q || (enq_fire && illegal);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[tail_q] <= fmt;
  end
endmodule

// File: tb/tb_parc_dmemresp_queue.sv
// tb_parc_dmemresp_queue: directed checks of the dmem response queue in three configurations
module tb_parc_dmemresp_queue;
  import parc_dmemresp_pkg::*;
  logic clk = 1'b0, reset = 1'b1, enq_val = 1'b0, deq_rdy = 1'b0;
  logic [31:0] enq_data = '0;
  logic [2:0] enq_type = '0;
  logic [1:0] enq_offset = '0;
  logic a_enq_rdy, a_deq_val, a_full, a_empty, a_err;
  logic b_enq_rdy, b_deq_val, b_full, b_empty, b_err;
  logic c_enq_rdy, c_deq_val, c_full, c_empty, c_err;
  logic [31:0] a_data, b_data, c_data;
  logic [4:0] a_count, b_count, c_count;
  int passes = 0, fails = 0;
  ld_type_t v_typ [6] = '{LD_BU, LD_H, LD_H, LD_B, LD_BU, LD_HU};
  logic [31:0] v_dat [6] = '{32'h1234_80FF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
  logic [1:0] v_off [6] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1};
  logic [31:0] v_exp [6] = '{32'h0000_00FF, 32'hFFFF_8001, 32'h0000_7FFF, 32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7FFF};

  parc_dmemresp_queue dut (
    .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(a_enq_rdy), .enq_data(enq_data),
    .enq_type(enq_type), .enq_offset(enq_offset), .deq_val(a_deq_val), .deq_rdy(deq_rdy),
    .deq_data(a_data), .count(a_count), .full(a_full), .empty(a_empty), .err_type(a_err)
  );
  parc_dmemresp_queue #(.p_depth(3)) dut3 (
    .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(b_enq_rdy), .enq_data(enq_data),
    .enq_type(enq_type), .enq_offset(enq_offset), .deq_val(b_deq_val), .deq_rdy(deq_rdy),
    .deq_data(b_data), .count(b_count), .full(b_full), .empty(b_empty), .err_type(b_err)
  );
  parc_dmemresp_queue #(.p_bypass(1'b0)) dutnb (
    .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(c_enq_rdy), .enq_data(enq_data),
    .enq_type(enq_type), .enq_offset(enq_offset), .deq_val(c_deq_val), .deq_rdy(deq_rdy),
    .deq_data(c_data), .count(c_count), .full(c_full), .empty(c_empty), .err_type(c_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] d, input logic [1:0] o);
    enq_val = v;
    enq_type = t;
    enq_data = d;
    enq_offset = o;
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_deq_val", 32'(a_deq_val), 32'd0);
    chk("rst_enq_rdy", 32'(a_enq_rdy), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_enq_rdy", 32'(a_enq_rdy), 32'd1);
    deq_rdy = 1'b1;
    drive(1'b1, LD_B, 32'h1234_80FF, 2'd1);
    #1;
    chk("bypass_val", 32'(a_deq_val), 32'd1);
    chk("bypass_lb", a_data, 32'hFFFF_FF80);
    tick();
    chk("bypass_count", 32'(a_count), 32'd0);
    chk("bypass_empty", 32'(a_empty), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, v_typ[i], v_dat[i], v_off[i]);
      #1;
      chk("fmt", a_data, v_exp[i]);
      tick();
    end
    chk("fmt_count", 32'(a_count), 32'd0);
    deq_rdy = 1'b0;
    drive(1'b1, LD_HU, 32'hBEEF_0001, 2'd2);
    #1;
    chk("offer_val", 32'(a_deq_val), 32'd1);
    chk("offer_data", a_data, 32'h0000_BEEF);
    tick();
    chk("offer_count", 32'(a_count), 32'd1);
    drive(1'b1, LD_W, 32'hCAFE_F00D, 2'd0);
    tick();
    chk("full", 32'(a_full), 32'd1);
    chk("full_enq_rdy", 32'(a_enq_rdy), 32'd0);
    chk("full_count", 32'(a_count), 32'd2);
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    #1;
    chk("drain0", a_data, 32'h0000_BEEF);
    tick();
    chk("drain1", a_data, 32'hCAFE_F00D);
    chk("drain1_count", 32'(a_count), 32'd1);
    tick();
    chk("drain_empty", 32'(a_empty), 32'd1);
    chk("drain_deq_val", 32'(a_deq_val), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    deq_rdy = 1'b0;
    drive(1'b1, LD_W, word(0), 2'd0);
    tick();
    chk("stream_prefill", 32'(b_count), 32'd1);
    deq_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, LD_W, word(i + 1), 2'd0);
      #1;
      chk("stream_val", 32'(b_deq_val), 32'd1);
      chk("stream_data", b_data, word(i));
      tick();
      chk("stream_count", 32'(b_count), 32'd1);
    end
    enq_val = 1'b0;
    #1;
    chk("stream_last", b_data, word(10));
    tick();
    chk("stream_empty", 32'(b_empty), 32'd1);
    drive(1'b1, 3'd6, 32'hFFFF_FFFF, 2'd0);
    #1;
    chk("ill_data", a_data, 32'h0);
    chk("ill_err_pre", 32'(a_err), 32'd0);
    tick();
    chk("ill_err", 32'(a_err), 32'd1);
    enq_val = 1'b0;
    tick();
    tick();
    chk("ill_err_sticky", 32'(a_err), 32'd1);
    deq_rdy = 1'b0;
    drive(1'b1, LD_W, 32'hAAAA_0001, 2'd0);
    tick();
    drive(1'b1, LD_W, 32'hAAAA_0002, 2'd0);
    tick();
    chk("mid_count", 32'(a_count), 32'd2);
    enq_val = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_count", 32'(a_count), 32'd0);
    chk("async_deq_val", 32'(a_deq_val), 32'd0);
    chk("async_empty", 32'(a_empty), 32'd1);
    chk("async_full", 32'(a_full), 32'd0);
    chk("async_enq_rdy", 32'(a_enq_rdy), 32'd0);
    chk("async_err", 32'(a_err), 32'd0);
    drive(1'b1, LD_W, 32'hDEAD_0003, 2'd0);
    tick();
    chk("rst_hold_count", 32'(a_count), 32'd0);
    chk("rst_hold_deq_val", 32'(a_deq_val), 32'd0);
    enq_val = 1'b0;
    reset = 1'b0;
    #1;
    chk("rel_enq_rdy", 32'(a_enq_rdy), 32'd1);
    chk("rel_deq_val", 32'(a_deq_val), 32'd0);
    drive(1'b1, LD_W, 32'h5555_0003, 2'd0);
    tick();
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    #1;
    chk("rel_data", a_data, 32'h5555_0003);
    tick();
    chk("rel_empty", 32'(a_empty), 32'd1);
    drive(1'b1, LD_BU, 32'h9A00_0000, 2'd3);
    #1;
    chk("nb_val_now", 32'(c_deq_val), 32'd0);
    tick();
    enq_val = 1'b0;
    #1;
    chk("nb_val_next", 32'(c_deq_val), 32'd1);
    chk("nb_data", c_data, 32'h0000_009A);
    tick();
    chk("nb_drained", 32'(c_deq_val), 32'd0);
    chk("nb_empty", 32'(c_empty), 32'd1);
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule
